// File: rtl/hv_ang_trim_drive.sv
// HV dvdt trim drive: ramps off/on VBN trims and loads count-delay into the analog block.
// HV_TRIM_RAMP_EN: one-LSB-per-step ramp; undefined loads the target in a single step.
`timescale 1ns/1ps
module hv_ang_trim_drive #(
  parameter int         CLK_M       = 48,
  parameter logic [3:0] OFF_VBN_RST = 4'd8,
  parameter logic [3:0] ON_VBN_RST  = 4'd8,
  parameter logic [5:0] CNT_DEL_RST = 6'd0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_reg_dvdt_tm,
  input  logic       i_trim_wr_en,
  input  logic [7:0] i_trim_code,
  input  logic       i_cnt_del_wr_en,
  input  logic [5:0] i_cnt_del_cfg,
  output logic [3:0] o_off_vbn_set,
  output logic [3:0] o_on_vbn_set,
  output logic [5:0] o_cnt_del_set,
  output logic       o_busy,
  output logic       o_done
);

  localparam int SETTLE_CYC = (2001 * CLK_M + 999) / 1000;
  localparam int CW = $clog2(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE
  } state_e;

`ifdef HV_TRIM_RAMP_EN
  function automatic logic [3:0] ramp1(
    input logic [3:0] cur,
    input logic [3:0] tgt
  );
    if (cur < tgt) ramp1 = cur + 4'd1;
    else if (cur > tgt) ramp1 = cur - 4'd1;
    else ramp1 = cur;
  endfunction
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [3:0]    off_q, off_d;
  logic [3:0]    on_q, on_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [5:0]    del_q, del_d;
  logic          pend_q, pend_d;
  logic [5:0]    pval_q, pval_d;
  logic [3:0]    off_nxt, on_nxt;
  logic          frz_trim, frz_del;

  assign frz_trim = (i_reg_dvdt_tm == 8'h80);
  assign frz_del  = (i_reg_dvdt_tm == 8'h40);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    on_d    = on_q;
    done_d  = 1'b0;
    tgt_d   = i_trim_wr_en ? i_trim_code : tgt_q;
`ifdef HV_TRIM_RAMP_EN
    off_nxt = ramp1(off_q, tgt_d[7:4]);
    on_nxt  = ramp1(on_q, tgt_d[3:0]);
`else
    off_nxt = tgt_d[7:4];
    on_nxt  = tgt_d[3:0];
`endif
    unique case (state_q)
      IDLE: begin
        if (i_trim_wr_en) begin
          if (i_trim_code == {off_q, on_q}) done_d = 1'b1;
          else state_d = STEP;
        end
      end
      STEP: begin
        if (!frz_trim) begin
          off_d   = off_nxt;
          on_d    = on_nxt;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!frz_trim) begin
          if (cnt_q == CNT_LAST) begin
            if (tgt_d == {off_q, on_q}) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = STEP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A write during freeze parks in pend; a write always beats the parked value.
  always_comb begin
    del_d  = del_q;
    pend_d = pend_q;
    pval_d = pval_q;
    if (i_cnt_del_wr_en) begin
      if (frz_del) begin
        pend_d = 1'b1;
        pval_d = i_cnt_del_cfg;
      end else begin
        del_d  = i_cnt_del_cfg;
        pend_d = 1'b0;
      end
    end else if (pend_q && !frz_del) begin
      del_d  = pval_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= {OFF_VBN_RST, ON_VBN_RST};
      off_q   <= OFF_VBN_RST;
      on_q    <= ON_VBN_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      del_q   <= CNT_DEL_RST;
      pend_q  <= 1'b0;
      pval_q  <= CNT_DEL_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      off_q   <= off_d;
      on_q    <= on_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      del_q   <= del_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
    end
  end

  assign o_off_vbn_set = off_q;
  assign o_on_vbn_set  = on_q;
  assign o_cnt_del_set = del_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_hv_ang_trim_drive.sv
// Bench for hv_ang_trim_drive: random trim ramps, freeze, retarget, cnt_del, reset.
// Expected trajectories come from step counts and settle timing arithmetic.
`timescale 1ns/1ps
module tb_hv_ang_trim_drive;

  localparam int SETTLE = (2001 * 48 + 999) / 1000;
  localparam int SC1 = SETTLE + 1;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_reg_dvdt_tm = 8'h00;
  logic       i_trim_wr_en = 1'b0;
  logic [7:0] i_trim_code = 8'h00;
  logic       i_cnt_del_wr_en = 1'b0;
  logic [5:0] i_cnt_del_cfg = 6'd0;
  logic [3:0] o_off_vbn_set;
  logic [3:0] o_on_vbn_set;
  logic [5:0] o_cnt_del_set;
  logic       o_busy;
  logic       o_done;

  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] m_off = 4'd8;
  logic [3:0] m_on = 4'd8;
  logic [5:0] m_cnt = 6'd0;

  hv_ang_trim_drive #(
    .CLK_M(48),
    .OFF_VBN_RST(4'd8),
    .ON_VBN_RST(4'd8),
    .CNT_DEL_RST(6'd0)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_reg_dvdt_tm(i_reg_dvdt_tm),
    .i_trim_wr_en(i_trim_wr_en),
    .i_trim_code(i_trim_code),
    .i_cnt_del_wr_en(i_cnt_del_wr_en),
    .i_cnt_del_cfg(i_cnt_del_cfg),
    .o_off_vbn_set(o_off_vbn_set),
    .o_on_vbn_set(o_on_vbn_set),
    .o_cnt_del_set(o_cnt_del_set),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic int dist4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
  endfunction

  function automatic int nsteps(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef HV_TRIM_RAMP_EN
    int a, b;
    a = dist4(cur[7:4], tgt[7:4]);
    b = dist4(cur[3:0], tgt[3:0]);
    return (a > b) ? a : b;
`else
    return (cur != tgt) ? 1 : 0;
`endif
  endfunction

  function automatic logic [3:0] after_k(
    input logic [3:0] c,
    input logic [3:0] t,
    input int k
  );
`ifdef HV_TRIM_RAMP_EN
    int d, m;
    d = dist4(c, t);
    m = (k < d) ? k : d;
    return (c < t) ? 4'(int'(c) + m) : 4'(int'(c) - m);
`else
    return (k >= 1) ? t : c;
`endif
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_trim_wr_en = 1'b0;
    i_cnt_del_wr_en = 1'b0;
    i_reg_dvdt_tm = 8'h00;
    i_rst_n = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    m_off = 4'd8;
    m_on = 4'd8;
    m_cnt = 6'd0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (o_off_vbn_set !== 4'd8 || o_on_vbn_set !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_trim got %h/%h exp 8/8", o_off_vbn_set, o_on_vbn_set);
    end
    n_tests++;
    if (o_cnt_del_set !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d exp 0", o_cnt_del_set);
    end
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b done=%b exp 0/0", o_busy, o_done);
    end
  endtask

  task automatic run_traj(input logic [7:0] code, input logic [7:0] tm, input string nm);
    int n, last, k;
    bit bad;
    logic [3:0] eo, en;
    logic eb, ed;
    n = nsteps({m_off, m_on}, code);
    last = n * SC1;
    i_reg_dvdt_tm = tm;
    i_trim_code = code;
    i_trim_wr_en = 1'b1;
    tick();
    i_trim_wr_en = 1'b0;
    n_tests++;
    if (o_done !== (n == 0) || o_busy !== (n != 0)) begin
      n_fail++;
      $display("FAIL %s_wr_edge busy=%b done=%b exp busy=%b done=%b",
               nm, o_busy, o_done, n != 0, n == 0);
    end
    bad = 1'b0;
    for (int t = 1; t <= last + 1 && !bad; t++) begin
      tick();
      k = (t - 1) / SC1 + 1;
      if (k > n) k = n;
      eo = after_k(m_off, code[7:4], k);
      en = after_k(m_on, code[3:0], k);
      eb = (t < last);
      ed = (t == last);
      n_tests++;
      if ({o_off_vbn_set, o_on_vbn_set, o_busy, o_done} !== {eo, en, eb, ed}) begin
        n_fail++;
        bad = 1'b1;
        $display("FAIL %s t=%0d got off=%h on=%h busy=%b done=%b exp off=%h on=%h busy=%b done=%b",
                 nm, t, o_off_vbn_set, o_on_vbn_set, o_busy, o_done, eo, en, eb, ed);
      end
    end
    m_off = code[7:4];
    m_on = code[3:0];
    i_reg_dvdt_tm = 8'h00;
  endtask

  task automatic test_equal_target();
    do_reset();
    run_traj(8'h88, 8'h00, "equal");
  endtask

  task automatic test_ramp_b8();
    do_reset();
    run_traj(8'hB8, 8'h00, "ramp_b8");
  endtask

  task automatic test_random();
    logic [7:0] tms [5] = '{8'h00, 8'h40, 8'h81, 8'hC0, 8'h7F};
    for (int i = 0; i < 6; i++) begin
      run_traj(8'($urandom), tms[$urandom_range(0, 4)], "rand");
    end
  endtask

  task automatic test_freeze();
    int n, last, done_e;
    bit hold_ok;
    logic [3:0] eo;
    do_reset();
    n = nsteps(8'h88, 8'h38);
    last = n * SC1;
    eo = after_k(4'd8, 4'd3, 1);
    i_trim_code = 8'h38;
    i_trim_wr_en = 1'b1;
    tick();
    i_trim_wr_en = 1'b0;
    done_e = -1;
    hold_ok = 1'b1;
    for (int t = 1; t <= last + 60 && done_e < 0; t++) begin
      tick();
      if (t > 20 && t <= 70 && (o_off_vbn_set !== eo || o_busy !== 1'b1)) hold_ok = 1'b0;
      if (o_done === 1'b1) done_e = t;
      if (t == 20) i_reg_dvdt_tm = 8'h80;
      if (t == 70) i_reg_dvdt_tm = 8'h00;
    end
    i_reg_dvdt_tm = 8'h00;
    n_tests++;
    if (!hold_ok) begin
      n_fail++;
      $display("FAIL freeze_hold outputs moved during freeze exp off=%h", eo);
    end
    n_tests++;
    if (done_e != last + 50) begin
      n_fail++;
      $display("FAIL freeze_done got edge %0d exp %0d", done_e, last + 50);
    end
    n_tests++;
    if (o_off_vbn_set !== 4'h3 || o_on_vbn_set !== 4'h8) begin
      n_fail++;
      $display("FAIL freeze_final got %h%h exp 38", o_off_vbn_set, o_on_vbn_set);
    end
    m_off = 4'h3;
  endtask

  task automatic test_retarget();
    logic [3:0] v, v1, prev;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int n2, exp_done, done_e;
    bit ok;
    do_reset();
    v1 = after_k(4'd8, 4'hA, 1);
    n2 = nsteps({v1, 4'd8}, 8'h78);
    exp_done = SC1 * (1 + n2);
    v = v1;
    exp_q.push_back(v);
    for (int i = 0; i < n2; i++) begin
      v = after_k(v, 4'h7, 1);
      exp_q.push_back(v);
    end
    prev = 4'd8;
    i_trim_code = 8'hA8;
    i_trim_wr_en = 1'b1;
    tick();
    i_trim_wr_en = 1'b0;
    done_e = -1;
    for (int t = 1; t <= exp_done + 20 && done_e < 0; t++) begin
      tick();
      if (o_off_vbn_set !== prev) begin
        obs_q.push_back(o_off_vbn_set);
        prev = o_off_vbn_set;
      end
      if (o_done === 1'b1) done_e = t;
      i_trim_wr_en = (t == 30);
      i_trim_code = 8'h78;
    end
    i_trim_wr_en = 1'b0;
    ok = (obs_q.size() == exp_q.size());
    if (ok) begin
      for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL retarget_seq got %0d values exp %0d, last got=%h exp=%h",
               obs_q.size(), exp_q.size(), prev, exp_q[exp_q.size()-1]);
    end
    n_tests++;
    if (done_e != exp_done || o_on_vbn_set !== 4'd8) begin
      n_fail++;
      $display("FAIL retarget_done got edge %0d on=%h exp edge %0d on=8",
               done_e, o_on_vbn_set, exp_done);
    end
    m_off = 4'h7;
  endtask

  task automatic cnt_write(input logic [5:0] v);
    i_cnt_del_cfg = v;
    i_cnt_del_wr_en = 1'b1;
    tick();
    i_cnt_del_wr_en = 1'b0;
  endtask

  task automatic chk_cnt(input string nm);
    n_tests++;
    if (o_cnt_del_set !== m_cnt) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", nm, o_cnt_del_set, m_cnt);
    end
  endtask

  function automatic logic [5:0] diff_val(input logic [5:0] p);
    return 6'((int'(p) + 1 + $urandom_range(0, 61)) % 64);
  endfunction

  task automatic test_cnt_del();
    logic [5:0] a, b;
    i_reg_dvdt_tm = 8'h00;
    m_cnt = diff_val(m_cnt);
    cnt_write(m_cnt);
    chk_cnt("cnt_direct");
    i_reg_dvdt_tm = 8'h40;
    cnt_write(6'd21);
    chk_cnt("cnt_frz_21");
    cnt_write(6'd42);
    repeat (3) tick();
    chk_cnt("cnt_frz_42");
    i_reg_dvdt_tm = 8'h00;
    tick();
    m_cnt = 6'd42;
    chk_cnt("cnt_release");
    a = diff_val(m_cnt);
    b = diff_val(a);
    i_reg_dvdt_tm = 8'h40;
    cnt_write(a);
    i_reg_dvdt_tm = 8'h00;
    cnt_write(b);
    m_cnt = b;
    chk_cnt("cnt_wr_release");
    i_reg_dvdt_tm = 8'h40;
    tick();
    i_reg_dvdt_tm = 8'h00;
    tick();
    chk_cnt("cnt_no_stale");
    i_reg_dvdt_tm = 8'h80;
    m_cnt = diff_val(m_cnt);
    cnt_write(m_cnt);
    chk_cnt("cnt_tm80");
    i_reg_dvdt_tm = 8'h41;
    m_cnt = diff_val(m_cnt);
    cnt_write(m_cnt);
    chk_cnt("cnt_tm41");
    i_reg_dvdt_tm = 8'h00;
  endtask

  task automatic test_reset_mid_ramp();
    bit quiet;
    do_reset();
    cnt_write(6'd33);
    i_trim_code = 8'hF0;
    i_trim_wr_en = 1'b1;
    tick();
    i_trim_wr_en = 1'b0;
    repeat (150) tick();
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_off_vbn_set, o_on_vbn_set, o_cnt_del_set, o_busy, o_done} !==
        {4'd8, 4'd8, 6'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid got off=%h on=%h cnt=%0d busy=%b done=%b exp 8/8/0/0/0",
               o_off_vbn_set, o_on_vbn_set, o_cnt_del_set, o_busy, o_done);
    end
    #3;
    i_rst_n = 1'b1;
    quiet = 1'b1;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (o_done !== 1'b0 || o_busy !== 1'b0 ||
          o_off_vbn_set !== 4'd8 || o_on_vbn_set !== 4'd8) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL rst_after got activity busy=%b done=%b off=%h exp idle 8/8",
               o_busy, o_done, o_off_vbn_set);
    end
    m_off = 4'd8;
    m_on = 4'd8;
    m_cnt = 6'd0;
  endtask

  initial begin
    test_reset();
    test_equal_target();
    test_ramp_b8();
    test_random();
    test_freeze();
    test_retarget();
    test_cnt_del();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
